// File: rtl/slice_lutn_ram_pkg.sv
// Shared constants and X-aware helpers for the LUT4 slice model.
// mux16 and data_same resolve unknown selects by merging all candidate entries.
package slice_pkg;

  localparam string MODE_LOGIC = "LOGIC";
  localparam string MODE_RAM   = "RAM";
  localparam string MODE_SHIFT = "SHIFT";

  localparam string MMUX_SIG = "SIG";
  localparam string MMUX_INV = "INV";
  localparam string MMUX_VLO = "VLO";
  localparam string MMUX_VHI = "VHI";

  // An unknown pattern bit matches both values of the entry bit.
  function automatic logic addr_match(input logic [3:0] entry, input logic [3:0] pattern);
    logic hit;
    hit = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if ((pattern[b] === 1'b0 && entry[b]) || (pattern[b] === 1'b1 && !entry[b])) begin
        hit = 1'b0;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  function automatic logic data_same(input logic a, input logic b);
    if ((a === b) && ((a === 1'b0) || (a === 1'b1))) begin
      return a;
    end else begin
      return 1'bx;
    end
  endfunction

  function automatic logic mux16(input logic [15:0] data, input logic [3:0] sel);
    logic res;
    logic first;
    res   = 1'b0;
    first = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (addr_match(4'(j), sel)) begin
        res   = first ? data_same(data[j], data[j]) : data_same(res, data[j]);
        first = 1'b0;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/slice_lutn_ram_lut16.sv
// One LUT4 cell: 16-bit storage usable as ROM, 16x1 RAM or SRL16,
// with X-merging read mux and shift-out tap.
module slice_lut16
  import slice_pkg::*;
#(
  parameter string       MODE    = "LOGIC",
  parameter logic [15:0] INITVAL = 16'h0000,
  parameter logic        XON     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       wre,
  input  logic [3:0] wad,
  input  logic       wd,
  input  logic [3:0] addr,
  output logic       f,
  output logic       so
);

  localparam logic IS_RAM   = (MODE == MODE_RAM);
  localparam logic IS_SHIFT = (MODE == MODE_SHIFT);

  logic [15:0] mem_r;
  logic [15:0] mem_nxt_s;
  logic        ce_on_s;
  logic        wre_on_s;
  logic        wre_x_s;
  logic        wad_x_s;
  logic        x_hit_s;

  // Next cell contents: RAM write, SRL shift, or X corruption on unknown controls.
  always_comb begin
    ce_on_s   = (ce === 1'b1);
    wre_on_s  = (wre === 1'b1);
    wre_x_s   = (wre !== 1'b0) && (wre !== 1'b1);
    wad_x_s   = $isunknown(wad);
    x_hit_s   = XON && ce_on_s && (wre_x_s || (IS_RAM && wre_on_s && wad_x_s));
    mem_nxt_s = mem_r;
    if (IS_RAM) begin
      for (int j = 0; j < 16; j++) begin
        if (!addr_match(4'(j), wad)) begin
          mem_nxt_s[j] = mem_r[j];
        end else if (x_hit_s) begin
          mem_nxt_s[j] = 1'bx;
        end else if (ce_on_s && wre_on_s && !wad_x_s) begin
          mem_nxt_s[j] = wd;
        end else begin
          mem_nxt_s[j] = mem_r[j];
        end
      end
    end else if (IS_SHIFT) begin
      if (x_hit_s) begin
        mem_nxt_s = {16{1'bx}};
      end else if (ce_on_s && wre_on_s) begin
        mem_nxt_s = {mem_r[14:0], wd};
      end else begin
        mem_nxt_s = mem_r;
      end
    end else begin
      mem_nxt_s = mem_r;
    end
  end

  // Cell storage; reset reloads the init pattern and drops any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r <= INITVAL;
    end else begin
      mem_r <= mem_nxt_s;
    end
  end

  assign f  = mux16(mem_r, addr);
  assign so = IS_SHIFT ? mem_r[15] : 1'b0;

endmodule

// File: rtl/slice_lutn_ram.sv
// Generic slice of NUM_LUT LUT4 cells, paired through OFX wide-function muxes,
// with an optional output register bank.
module slice_lutn_ram
  import slice_pkg::*;
#(
  parameter int                    NUM_LUT     = 2,
  parameter string                 MODE        = "LOGIC",
  parameter logic [16*NUM_LUT-1:0] LUT_INITVAL = {(16*NUM_LUT){1'b0}},
  parameter string                 MMUX        = "SIG",
  parameter logic                  REG_OUT     = 1'b0,
  parameter logic                  XON         = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   CE,
  input  logic                   WRE,
  input  logic [3:0]             WAD,
  input  logic [NUM_LUT-1:0]     WD,
  input  logic [4*NUM_LUT-1:0]   ADDR,
  input  logic [NUM_LUT/2-1:0]   M,
  output logic [NUM_LUT-1:0]     F,
  output logic [NUM_LUT/2-1:0]   OFX,
  output logic [NUM_LUT-1:0]     Q,
  output logic [NUM_LUT-1:0]     SO
);

  localparam logic SEL_HI  = (MMUX == MMUX_VHI);
  localparam logic SEL_LO  = (MMUX == MMUX_VLO);
  localparam logic SEL_INV = (MMUX == MMUX_INV);

  logic [NUM_LUT-1:0]   f_s;
  logic [NUM_LUT-1:0]   q_r;
  logic [NUM_LUT/2-1:0] sel_s;

  for (genvar i = 0; i < NUM_LUT; i++) begin : g_cell
    slice_lut16 #(
      .MODE   (MODE),
      .INITVAL(LUT_INITVAL[16*i +: 16]),
      .XON    (XON)
    ) u_cell (
      .clk  (CLK),
      .rst_n(RSTN),
      .ce   (CE),
      .wre  (WRE),
      .wad  (WAD),
      .wd   (WD[i]),
      .addr (ADDR[4*i +: 4]),
      .f    (f_s[i]),
      .so   (SO[i])
    );
  end

  // OFX select source per pair.
  always_comb begin
    if (SEL_HI) begin
      sel_s = {(NUM_LUT/2){1'b1}};
    end else if (SEL_LO) begin
      sel_s = {(NUM_LUT/2){1'b0}};
    end else if (SEL_INV) begin
      sel_s = ~M;
    end else begin
      sel_s = M;
    end
  end

  // Wide-function mux; an unknown select merges both inputs.
  always_comb begin
    OFX = {(NUM_LUT/2){1'b0}};
    for (int k = 0; k < NUM_LUT/2; k++) begin
      if (sel_s[k] === 1'b1) begin
        OFX[k] = f_s[2*k+1];
      end else if (sel_s[k] === 1'b0) begin
        OFX[k] = f_s[2*k];
      end else begin
        OFX[k] = data_same(f_s[2*k], f_s[2*k+1]);
      end
    end
  end

  // Output register bank; samples pre-write F on a write edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_r <= {NUM_LUT{1'b0}};
    end else if (CE) begin
      q_r <= f_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign F = f_s;
  assign Q = REG_OUT ? q_r : f_s;

endmodule

// File: tb/tb_slice_lutn_ram.sv
// Directed bench for slice_lutn_ram: several configurations share one stimulus bus.
// X-propagation vectors run only when the simulator models four-state values.
module tb_slice_lutn_ram;

  logic       CLK;
  logic       RSTN;
  logic       CE;
  logic       WRE;
  logic [3:0] WAD;
  logic [1:0] WD;
  logic [7:0] ADDR;
  logic [0:0] M;

  logic [1:0] f_lg, q_lg, so_lg, f_ram, q_ram, so_ram, f_rx0, q_rx0, so_rx0;
  logic [1:0] f_sh, q_sh, so_sh, f_vhi, q_vhi, so_vhi;
  logic [0:0] ofx_lg, ofx_ram, ofx_rx0, ofx_sh, ofx_vhi;

  int   n_vec;
  int   n_bad;
  logic four_state;
  logic probe_x;

  slice_lutn_ram #(.NUM_LUT(2), .MODE("LOGIC"), .LUT_INITVAL({16'h0003, 16'hCAFE}),
    .MMUX("SIG"), .REG_OUT(1'b0), .XON(1'b0)) u_logic (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WRE(WRE), .WAD(WAD), .WD(WD), .ADDR(ADDR), .M(M),
    .F(f_lg), .OFX(ofx_lg), .Q(q_lg), .SO(so_lg));

  slice_lutn_ram #(.NUM_LUT(2), .MODE("RAM"), .LUT_INITVAL(32'h0000_0000),
    .MMUX("SIG"), .REG_OUT(1'b1), .XON(1'b1)) u_ram (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WRE(WRE), .WAD(WAD), .WD(WD), .ADDR(ADDR), .M(M),
    .F(f_ram), .OFX(ofx_ram), .Q(q_ram), .SO(so_ram));

  slice_lutn_ram #(.NUM_LUT(2), .MODE("RAM"), .LUT_INITVAL(32'h0000_0000),
    .MMUX("SIG"), .REG_OUT(1'b0), .XON(1'b0)) u_ramx0 (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WRE(WRE), .WAD(WAD), .WD(WD), .ADDR(ADDR), .M(M),
    .F(f_rx0), .OFX(ofx_rx0), .Q(q_rx0), .SO(so_rx0));

  slice_lutn_ram #(.NUM_LUT(2), .MODE("SHIFT"), .LUT_INITVAL(32'h0000_0000),
    .MMUX("SIG"), .REG_OUT(1'b0), .XON(1'b0)) u_shift (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WRE(WRE), .WAD(WAD), .WD(WD), .ADDR(ADDR), .M(M),
    .F(f_sh), .OFX(ofx_sh), .Q(q_sh), .SO(so_sh));

  slice_lutn_ram #(.NUM_LUT(2), .MODE("LOGIC"), .LUT_INITVAL({16'hFFFF, 16'h0000}),
    .MMUX("VHI"), .REG_OUT(1'b0), .XON(1'b0)) u_vhi (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WRE(WRE), .WAD(WAD), .WD(WD), .ADDR(ADDR), .M(M),
    .F(f_vhi), .OFX(ofx_vhi), .Q(q_vhi), .SO(so_vhi));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    RSTN = 1'b0;
    CE   = 1'b0;
    WRE  = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    RSTN = 1'b1; CE = 1'b0; WRE = 1'b0; WAD = 4'd0; WD = 2'b00; ADDR = 8'h00; M = 1'b0;
    #1 RSTN = 1'b0;
    #1;
    n_vec++; if (q_ram !== 2'b00) begin n_bad++; $display("FAIL rst_q_ram: got %b want 00", q_ram); end
    n_vec++; if (f_lg !== 2'b10) begin n_bad++; $display("FAIL rst_f_logic: got %b want 10", f_lg); end
    n_vec++; if (q_lg !== 2'b10) begin n_bad++; $display("FAIL rst_q_logic: got %b want 10", q_lg); end
    n_vec++; if (q_vhi !== 2'b10) begin n_bad++; $display("FAIL rst_q_vhi: got %b want 10", q_vhi); end
    n_vec++; if ({q_sh, q_rx0} !== 4'b0000) begin n_bad++; $display("FAIL rst_q_sh_rx0: got %b want 0000", {q_sh, q_rx0}); end
    n_vec++; if ({so_lg, so_ram, so_rx0, so_sh, so_vhi} !== 10'b0) begin
      n_bad++; $display("FAIL rst_so: got %b want 0", {so_lg, so_ram, so_rx0, so_sh, so_vhi}); end
    n_vec++; if ({ofx_ram, ofx_rx0, ofx_sh} !== 3'b000) begin
      n_bad++; $display("FAIL rst_ofx: got %b want 000", {ofx_ram, ofx_rx0, ofx_sh}); end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_logic();
    logic [15:0] init0;
    logic [15:0] init1;
    init0 = 16'hCAFE;
    init1 = 16'h0003;
    do_reset();
    CE = 1'b1; WRE = 1'b1; WD = 2'b11;
    for (int a = 0; a < 16; a++) begin
      @(negedge CLK);
      ADDR = {4'(a), 4'(a)};
      WAD  = 4'(a);
      #1;
      n_vec++; if (f_lg !== {init1[a], init0[a]}) begin
        n_bad++; $display("FAIL logic_sweep a=%0d: got %b want %b", a, f_lg, {init1[a], init0[a]}); end
    end
    CE = 1'b0; WRE = 1'b0;
    ADDR = {4'b000x, 4'b0010};
    #1;
    n_vec++; if (f_lg[1] !== 1'b1) begin n_bad++; $display("FAIL logic_xmerge_same: got %b want 1", f_lg[1]); end
    if (four_state) begin
      ADDR = {4'b0000, 4'b000x};
      #1;
      n_vec++; if (f_lg[0] !== 1'bx) begin n_bad++; $display("FAIL logic_xmerge_diff: got %b want x", f_lg[0]); end
    end
  endtask

  task automatic test_ram();
    do_reset();
    @(negedge CLK);
    CE = 1'b1; WRE = 1'b1; WAD = 4'd5; WD = 2'b01; ADDR = {4'd5, 4'd5};
    #1;
    n_vec++; if (f_ram !== 2'b00) begin n_bad++; $display("FAIL ram_pre_edge: got %b want 00", f_ram); end
    @(posedge CLK); #1;
    n_vec++; if (f_ram !== 2'b01) begin n_bad++; $display("FAIL ram_post_edge: got %b want 01", f_ram); end
    n_vec++; if (q_ram !== 2'b00) begin n_bad++; $display("FAIL ram_q_prewrite: got %b want 00", q_ram); end
    n_vec++; if (f_rx0 !== 2'b01) begin n_bad++; $display("FAIL ramx0_write: got %b want 01", f_rx0); end
    n_vec++; if (f_lg !== 2'b01) begin n_bad++; $display("FAIL logic_ignores_wre: got %b want 01", f_lg); end
    WRE = 1'b0;
    @(posedge CLK); #1;
    n_vec++; if (q_ram !== 2'b01) begin n_bad++; $display("FAIL ram_q_latency: got %b want 01", q_ram); end
    WRE = 1'b1; WAD = 4'd10; WD = 2'b11; ADDR = {4'd10, 4'd10};
    @(posedge CLK); #1;
    n_vec++; if (f_ram !== 2'b11) begin n_bad++; $display("FAIL ram_write10: got %b want 11", f_ram); end
    WRE = 1'b0; ADDR = {4'd5, 4'd5};
    #1;
    n_vec++; if (f_ram !== 2'b01) begin n_bad++; $display("FAIL ram_keep5: got %b want 01", f_ram); end
    ADDR = {4'd6, 4'd6};
    #1;
    n_vec++; if (f_ram !== 2'b00) begin n_bad++; $display("FAIL ram_untouched6: got %b want 00", f_ram); end
  endtask

  task automatic test_shift();
    logic [3:0] feed;
    logic [3:0] tap_exp;
    feed    = 4'b1101;
    tap_exp = 4'b1011;
    do_reset();
    ADDR = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      CE = 1'b1; WRE = 1'b1; WD = {~feed[k], feed[k]};
      @(posedge CLK); #1;
      n_vec++; if (f_sh !== {~feed[k], feed[k]}) begin
        n_bad++; $display("FAIL shift_in k=%0d: got %b want %b", k, f_sh, {~feed[k], feed[k]}); end
    end
    WRE = 1'b0;
    for (int n = 0; n < 4; n++) begin
      ADDR = {4'(n), 4'(n)};
      #1;
      n_vec++; if (f_sh !== {~tap_exp[n], tap_exp[n]}) begin
        n_bad++; $display("FAIL shift_tap n=%0d: got %b want %b", n, f_sh, {~tap_exp[n], tap_exp[n]}); end
    end
    n_vec++; if (so_sh !== 2'b00) begin n_bad++; $display("FAIL shift_so_early: got %b want 00", so_sh); end
    WRE = 1'b1; WD = 2'b00;
    repeat (12) @(posedge CLK);
    #1;
    n_vec++; if (so_sh !== 2'b01) begin n_bad++; $display("FAIL shift_so_first: got %b want 01", so_sh); end
    @(posedge CLK); #1;
    n_vec++; if (so_sh !== 2'b10) begin n_bad++; $display("FAIL shift_so_second: got %b want 10", so_sh); end
    WD = 2'b11;
    repeat (16) @(posedge CLK);
    #1;
    n_vec++; if (so_sh !== 2'b11) begin n_bad++; $display("FAIL shift_so_ones: got %b want 11", so_sh); end
    n_vec++; if (so_lg !== 2'b00) begin n_bad++; $display("FAIL logic_so_zero: got %b want 00", so_lg); end
    WRE = 1'b0; CE = 1'b0;
  endtask

  task automatic test_ofx();
    ADDR = 8'h00; M = 1'b0;
    #1;
    n_vec++; if (ofx_lg !== 1'b0) begin n_bad++; $display("FAIL ofx_m0: got %b want 0", ofx_lg); end
    M = 1'b1;
    #1;
    n_vec++; if (ofx_lg !== 1'b1) begin n_bad++; $display("FAIL ofx_m1: got %b want 1", ofx_lg); end
    ADDR = {4'h0, 4'h1}; M = 1'b0;
    #1;
    n_vec++; if (ofx_lg !== 1'b1) begin n_bad++; $display("FAIL ofx_same_m0: got %b want 1", ofx_lg); end
    M = 1'bx;
    #1;
    n_vec++; if (ofx_lg !== 1'b1) begin n_bad++; $display("FAIL ofx_same_mx: got %b want 1", ofx_lg); end
    if (four_state) begin
      ADDR = 8'h00;
      #1;
      n_vec++; if (ofx_lg !== 1'bx) begin n_bad++; $display("FAIL ofx_diff_mx: got %b want x", ofx_lg); end
    end
    M = 1'b0;
    #1;
    n_vec++; if (ofx_vhi !== 1'b1) begin n_bad++; $display("FAIL ofx_vhi: got %b want 1", ofx_vhi); end
    n_vec++; if (f_vhi !== 2'b10) begin n_bad++; $display("FAIL vhi_f: got %b want 10", f_vhi); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge CLK);
    CE = 1'b1; WRE = 1'b1; WAD = 4'd3; WD = 2'b11; ADDR = {4'd3, 4'd3};
    @(posedge CLK); #1;
    WRE = 1'b0;
    n_vec++; if (f_ram !== 2'b11) begin n_bad++; $display("FAIL rm_write3: got %b want 11", f_ram); end
    @(posedge CLK); #1;
    n_vec++; if (q_ram !== 2'b11) begin n_bad++; $display("FAIL rm_q_loaded: got %b want 11", q_ram); end
    @(negedge CLK);
    WRE = 1'b1; WAD = 4'd7; WD = 2'b11; RSTN = 1'b0;
    #1;
    n_vec++; if (q_ram !== 2'b00) begin n_bad++; $display("FAIL rm_q_async: got %b want 00", q_ram); end
    n_vec++; if (f_ram !== 2'b00) begin n_bad++; $display("FAIL rm_mem_init: got %b want 00", f_ram); end
    @(posedge CLK); #1;
    ADDR = {4'd7, 4'd7};
    #1;
    n_vec++; if (f_ram !== 2'b00) begin n_bad++; $display("FAIL rm_reset_wins: got %b want 00", f_ram); end
    @(negedge CLK);
    RSTN = 1'b1; WRE = 1'b0;
    ADDR = {4'd3, 4'd3};
    #1;
    n_vec++; if (f_ram !== 2'b00) begin n_bad++; $display("FAIL rm_after_release: got %b want 00", f_ram); end
    WRE = 1'b1; WAD = 4'd3; WD = 2'b11;
    @(posedge CLK); #1;
    WRE = 1'b0;
    @(posedge CLK); #1;
    CE = 1'b0; WRE = 1'b1; WD = 2'b00; ADDR = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++; if (q_ram !== 2'b11) begin n_bad++; $display("FAIL ce_hold_q: got %b want 11", q_ram); end
    n_vec++; if (f_ram !== 2'b00) begin n_bad++; $display("FAIL ce_hold_f0: got %b want 00", f_ram); end
    ADDR = {4'd3, 4'd3};
    #1;
    n_vec++; if (f_ram !== 2'b11) begin n_bad++; $display("FAIL ce_hold_mem: got %b want 11", f_ram); end
    WRE = 1'b0;
  endtask

  task automatic test_xon();
    do_reset();
    if (four_state) begin
      @(negedge CLK);
      CE = 1'b1; WRE = 1'b1; WAD = 4'b000x; WD = 2'b11;
      @(posedge CLK); #1;
      CE = 1'b0; WRE = 1'b0;
      for (int a = 0; a < 2; a++) begin
        ADDR = {4'(a), 4'(a)};
        #1;
        n_vec++; if (f_ram !== 2'bxx) begin n_bad++; $display("FAIL xon_corrupt a=%0d: got %b want xx", a, f_ram); end
        n_vec++; if (f_rx0 !== 2'b00) begin n_bad++; $display("FAIL xoff_unchanged a=%0d: got %b want 00", a, f_rx0); end
      end
      ADDR = {4'd2, 4'd2};
      #1;
      n_vec++; if (f_ram !== 2'b00) begin n_bad++; $display("FAIL xon_spare2: got %b want 00", f_ram); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    probe_x = 1'bx;
    four_state = $isunknown(probe_x);
    test_reset();
    test_logic();
    test_ram();
    test_shift();
    test_ofx();
    test_reset_mid();
    test_xon();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
